// File: rtl/bi_mem_tp_wm_clr.sv
`default_nettype none
// ============================================================================
// Module   : bi_mem_tp_wm_clr
// Purpose  : Single-clock 1R/1W memory with per-lane write mask, a valid-
//            qualified read pipeline (READ_LAT = 1 or 2) and a hardware clear
//            sequencer that sweeps CLEAR_VALUE into every entry after reset
//            and on request.
// Options  : define BI_MEM_TP_WM_CLR_BYPASS_EN to forward a same-cycle masked
//            write into a read of the same address.
// Revision : 1.0 - initial release
// ============================================================================
module bi_mem_tp_wm_clr #(
    parameter int               WIDTH       = 32,
    parameter int               HEIGHT      = 64,
    parameter int               MASK        = 4,
    parameter int               READ_LAT    = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clearReq_i,
    output logic                      busy_o,
    input  logic                      readEnable_i,
    input  logic [$clog2(HEIGHT)-1:0] readAddr_i,
    output logic [WIDTH-1:0]          readData_o,
    output logic                      readValid_o,
    input  logic                      writeEnable_i,
    input  logic [MASK-1:0]           writeMask_i,
    input  logic [$clog2(HEIGHT)-1:0] writeAddr_i,
    input  logic [WIDTH-1:0]          writeData_i
);

    localparam int ADDR_W = $clog2(HEIGHT);
    localparam int LANE_W = WIDTH / MASK;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    logic              clr_we;
    logic              rd_accept;
    logic              wr_accept;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [WIDTH-1:0]  rd_word;

    logic [WIDTH-1:0]  mem [HEIGHT];

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign rd_in_range = ({1'b0, readAddr_i}  < (ADDR_W+1)'(HEIGHT));
    assign wr_in_range = ({1'b0, writeAddr_i} < (ADDR_W+1)'(HEIGHT));

    // State register and sweep counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state: sweep every entry once, then wait for a clear request.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == ADDR_W'(HEIGHT - 1)) begin
                    state_nxt   = ST_READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (clearReq_i) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs and access qualification; a clear request swallows the
    // read/write presented alongside it.
    always_comb begin
        busy_o    = (state == ST_CLEAR);
        clr_we    = (state == ST_CLEAR);
        rd_accept = (state == ST_READY) && !clearReq_i && readEnable_i;
        wr_accept = (state == ST_READY) && !clearReq_i && writeEnable_i && wr_in_range;
    end

    // Array update: the sweep has priority; otherwise a lane-masked write.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else if (wr_accept) begin
            for (int k = 0; k < MASK; k++) begin
                if (writeMask_i[k]) begin
                    mem[writeAddr_i][k*LANE_W +: LANE_W] <= writeData_i[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Array sample for an accepted read; out-of-range addresses read as zero.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[readAddr_i];
`ifdef BI_MEM_TP_WM_CLR_BYPASS_EN
            if (wr_accept && (writeAddr_i == readAddr_i)) begin
                for (int k = 0; k < MASK; k++) begin
                    if (writeMask_i[k]) begin
                        rd_word[k*LANE_W +: LANE_W] = writeData_i[k*LANE_W +: LANE_W];
                    end
                end
            end
`else
            // Same-cycle collisions return the pre-write contents.
`endif
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             s1_valid;
            logic [WIDTH-1:0] s1_data;

            // Two-stage read pipeline; output data holds between pulses.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s1_valid    <= 1'b0;
                    s1_data     <= '0;
                    readValid_o <= 1'b0;
                    readData_o  <= '0;
                end else begin
                    s1_valid    <= rd_accept;
                    if (rd_accept) begin
                        s1_data <= rd_word;
                    end
                    readValid_o <= s1_valid;
                    if (s1_valid) begin
                        readData_o <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read pipeline; output data holds between pulses.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    readValid_o <= 1'b0;
                    readData_o  <= '0;
                end else begin
                    readValid_o <= rd_accept;
                    if (rd_accept) begin
                        readData_o <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bi_mem_tp_wm_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bi_mem_tp_wm_clr
// Purpose  : Bench for bi_mem_tp_wm_clr. Two instances share one stimulus
//            stream: HEIGHT=64/READ_LAT=1 and HEIGHT=48/READ_LAT=2. Each is
//            compared every cycle against a transaction-level model
//            (array + queue of pending read results).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bi_mem_tp_wm_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_mask = '0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int H = (g == 0) ? 64 : 48;
        localparam int L = (g == 0) ? 1 : 2;

        logic        busy;
        logic        rvalid;
        logic [31:0] rdata;

        bi_mem_tp_wm_clr #(
            .WIDTH      (32),
            .HEIGHT     (H),
            .MASK       (4),
            .READ_LAT   (L),
            .CLEAR_VALUE(32'h0)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .clearReq_i   (clear_req),
            .busy_o       (busy),
            .readEnable_i (rd_en),
            .readAddr_i   (rd_addr),
            .readData_o   (rdata),
            .readValid_o  (rvalid),
            .writeEnable_i(wr_en),
            .writeMask_i  (wr_mask),
            .writeAddr_i  (wr_addr),
            .writeData_i  (wr_data)
        );

        // Reference model state.
        logic [31:0] mem_m [H];
        int          busy_rem = H;
        int          cyc = 0;
        int          due_q[$];
        logic [31:0] dat_q[$];
        logic [31:0] last = '0;

        always @(posedge clk) begin
            logic [31:0] d;
            logic        exp_valid;
            cyc++;
            if (rst) begin
                due_q.delete();
                dat_q.delete();
                busy_rem = H;
                last     = '0;
                for (int i = 0; i < H; i++) mem_m[i] = '0;
            end else if (busy_rem > 0) begin
                busy_rem--;
            end else if (clear_req) begin
                busy_rem = H;
                for (int i = 0; i < H; i++) mem_m[i] = '0;
            end else begin
                if (rd_en) begin
                    d = (int'(rd_addr) < H) ? mem_m[rd_addr] : 32'h0;
`ifdef BI_MEM_TP_WM_CLR_BYPASS_EN
                    if (wr_en && wr_addr == rd_addr && int'(wr_addr) < H) begin
                        for (int k = 0; k < 4; k++)
                            if (wr_mask[k]) d[k*8 +: 8] = wr_data[k*8 +: 8];
                    end
`endif
                    due_q.push_back(cyc + L - 1);
                    dat_q.push_back(d);
                end
                if (wr_en && int'(wr_addr) < H) begin
                    for (int k = 0; k < 4; k++)
                        if (wr_mask[k]) mem_m[wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
                end
            end
            #1;
            exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
            if (exp_valid) begin
                last = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            check($sformatf("c%0d_busy", g),   {31'b0, busy},   {31'b0, busy_rem > 0});
            check($sformatf("c%0d_valid", g),  {31'b0, rvalid}, {31'b0, exp_valid});
            check($sformatf("c%0d_rdata", g),  rdata,           last);
        end
    end

    task automatic step(input logic cr, input logic re, input logic [5:0] ra,
                        input logic we, input logic [3:0] wm, input logic [5:0] wa,
                        input logic [31:0] wd);
        clear_req = cr; rd_en = re; rd_addr = ra;
        wr_en = we; wr_mask = wm; wr_addr = wa; wr_data = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n0;
        int n1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Sweep length after reset release.
        n0 = 0; n1 = 0;
        for (int i = 0; i < 300 && (g_cfg[0].busy || g_cfg[1].busy); i++) begin
            if (g_cfg[0].busy) n0++;
            if (g_cfg[1].busy) n1++;
            @(negedge clk);
        end
        check("busy_len_h64", n0, 64);
        check("busy_len_h48", n1, 48);

        // Cleared contents.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 31, 0, 0, 0, 0);
        step(0, 1, 63, 0, 0, 0, 0);
        idle(3);

        // Masked write then read.
        step(0, 0, 0, 1, 4'b1010, 5, 32'hAABBCCDD);
        step(0, 1, 5, 0, 0, 0, 0);
        idle(3);

        // Collision: read and masked write to the same address.
        step(0, 0, 0, 1, 4'b1111, 7, 32'h11223344);
        step(0, 1, 7, 1, 4'b0001, 7, 32'hFFFFFFFF);
        step(0, 1, 7, 0, 0, 0, 0);
        idle(3);

        // Clear request behind three back-to-back reads; write is dropped.
        step(0, 0, 0, 1, 4'b1111, 3, 32'h0BADF00D);
        step(0, 1, 5, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 1, 4'b1111, 2, 32'hDEADBEEF);
        for (int i = 0; i < 100 && (g_cfg[0].busy || g_cfg[1].busy); i++) @(negedge clk);
        step(0, 1, 2, 0, 0, 0, 0);
        idle(3);

        // Streaming reads of 0..9 after seeding them.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 4'b1111, 6'(i), 32'h1000_0000 + i);
        for (int i = 0; i < 10; i++) step(0, 1, 6'(i), 0, 0, 0, 0);
        idle(3);

        // Out-of-range write/read (only out of range for HEIGHT=48).
        step(0, 0, 0, 1, 4'b1111, 50, 32'hCAFEF00D);
        step(0, 1, 50, 0, 0, 0, 0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 149) == 0), $urandom_range(0, 1), 6'($urandom),
                 ($urandom_range(0, 2) != 0), 4'($urandom), 6'($urandom), $urandom);
        end

        // Reset with two reads in flight.
        for (int i = 0; i < 80 && (g_cfg[0].busy || g_cfg[1].busy); i++) idle(1);
        step(0, 1, 5, 0, 0, 0, 0);
        clear_req = 0; rd_en = 1; rd_addr = 7; wr_en = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        rd_en = 0;
        #1;
        check("rst_valid_h64", {31'b0, g_cfg[0].rvalid}, 32'h0);
        check("rst_valid_h48", {31'b0, g_cfg[1].rvalid}, 32'h0);
        check("rst_busy_h64",  {31'b0, g_cfg[0].busy},   32'h1);
        check("rst_busy_h48",  {31'b0, g_cfg[1].busy},   32'h1);
        check("rst_data_h64",  g_cfg[0].rdata,           32'h0);
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        // More random traffic after the reset.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 149) == 0), $urandom_range(0, 1), 6'($urandom),
                 ($urandom_range(0, 2) != 0), 4'($urandom), 6'($urandom), $urandom);
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
